// File: rtl/boot_loader.sv
// ============================================================================
// Module   : boot_loader
// Brief    : Parses a framed program image from the UART, writes it to program
//            memory, answers ACK/NAK and releases the core reset on success.
// Revision : 1.0
// ============================================================================
`default_nettype none

module boot_loader #(
    parameter int MEM_WORDS      = 8192,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        core_rst_n,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_DATA_LO = 3'd3,
        S_DATA_HI = 3'd4,
        S_CSUM    = 3'd5,
        S_RESP    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [7:0]  c_magic     = 8'hD1;
    localparam logic [7:0]  c_ack       = 8'h06;
    localparam logic [7:0]  c_nak       = 8'h15;
    localparam logic [16:0] c_max_words = 17'(MEM_WORDS);
    localparam logic [31:0] c_timeout   = 32'(TIMEOUT_CYCLES);

    state_t      r_state, w_state;
    logic [15:0] r_len, w_len;
    logic [15:0] r_ptr, w_ptr;
    logic [7:0]  r_csum, w_csum;
    logic [7:0]  r_lo, w_lo;
    logic [7:0]  r_resp, w_resp;
    logic [31:0] r_tmo;

    logic        w_mem_we;
    logic [15:0] w_mem_addr;
    logic [15:0] w_mem_data;
    logic        w_tx_start;
    logic [7:0]  w_tx_data;
    logic [15:0] w_ptr_inc;
    logic [15:0] w_len_full;
    logic        w_timed;
    logic        w_tmo_hit;

    assign w_ptr_inc  = r_ptr + 16'd1;
    assign w_len_full = {rx_data, r_len[7:0]};
    assign w_timed    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA_LO) || (r_state == S_DATA_HI) ||
                        (r_state == S_CSUM);
    assign w_tmo_hit  = w_timed && !rx_valid && (r_tmo == c_timeout);

    always_comb begin
        w_state    = r_state;
        w_len      = r_len;
        w_ptr      = r_ptr;
        w_csum     = r_csum;
        w_lo       = r_lo;
        w_resp     = r_resp;
        w_mem_we   = 1'b0;
        w_mem_addr = mem_addr;
        w_mem_data = mem_data;
        w_tx_start = 1'b0;
        w_tx_data  = tx_data;

        case (r_state)
            S_IDLE: begin
                if (rx_valid && rx_data == c_magic) begin
                    w_state = S_LEN_LO;
                    w_csum  = 8'h00;
                    w_ptr   = 16'h0000;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    w_len   = {r_len[15:8], rx_data};
                    w_state = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    w_len = w_len_full;
                    if ({1'b0, w_len_full} > c_max_words) begin
                        w_resp  = c_nak;
                        w_state = S_RESP;
                    end else if (w_len_full == 16'h0000) begin
                        w_state = S_CSUM;
                    end else begin
                        w_state = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (rx_valid) begin
                    w_lo    = rx_data;
                    w_csum  = r_csum + rx_data;
                    w_state = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (rx_valid) begin
                    w_csum     = r_csum + rx_data;
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_ptr;
                    w_mem_data = {rx_data, r_lo};
                    w_ptr      = w_ptr_inc;
                    w_state    = (w_ptr_inc == r_len) ? S_CSUM : S_DATA_LO;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    w_resp  = (rx_data == r_csum) ? c_ack : c_nak;
                    w_state = S_RESP;
                end
            end
            S_RESP: begin
                // Bytes arriving here are intentionally dropped.
                if (!tx_busy) begin
                    w_tx_start = 1'b1;
                    w_tx_data  = r_resp;
                    w_state    = (r_resp == c_ack) ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                w_state = S_DONE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_tmo_hit) begin
            w_state = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= 16'h0000;
            r_ptr      <= 16'h0000;
            r_csum     <= 8'h00;
            r_lo       <= 8'h00;
            r_resp     <= 8'h00;
            r_tmo      <= 32'd0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_data   <= 16'h0000;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_len      <= w_len;
            r_ptr      <= w_ptr;
            r_csum     <= w_csum;
            r_lo       <= w_lo;
            r_resp     <= w_resp;
            if (!w_timed || rx_valid) begin
                r_tmo <= 32'd0;
            end else if (r_tmo != c_timeout) begin
                r_tmo <= r_tmo + 32'd1;
            end
            tx_start   <= w_tx_start;
            tx_data    <= w_tx_data;
            mem_we     <= w_mem_we;
            mem_addr   <= w_mem_addr;
            mem_data   <= w_mem_data;
            // Registered from the current state so release lags the ACK pulse by one cycle.
            core_rst_n <= (r_state == S_DONE);
            busy       <= !((w_state == S_IDLE) || (w_state == S_DONE));
        end
    end

endmodule

`default_nettype wire
